param_dual_port_ram: RTL



---
 rtl/dpram_pkg.sv | 21 ++
 rtl/dpram_clear_seq.sv | 64 ++++++
 rtl/param_dual_port_ram.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/dpram_pkg.sv
// Shared definitions for the parametrised dual-port RAM: read-during-write
// mode codes, clear-sequencer state encoding and the even-parity helper.
package dpram_pkg;

  localparam int RD_FIRST  = 0;
  localparam int WR_FIRST  = 1;

  // Widest word the parity helper accepts; callers zero-extend to this width.
  localparam int PAR_MAX_W = 64;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] i_data);
    return ^i_data;
  endfunction

endpackage

// File: rtl/dpram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, asserting a write
// strobe, then parks in READY until the next reset.
module dpram_clear_seq
  import dpram_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_init_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ONE_ADDR  = {{(ADDR_W-1){1'b0}}, 1'b1};

  clr_state_e        r_state;
  clr_state_e        w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_next_addr;
  logic              r_busy;

  // Next-state and counter logic; clearing stops after the last address.
  always_comb begin
    w_next_state = r_state;
    w_next_addr  = r_addr;
    case (r_state)
      CLEAR: begin
        w_next_addr = r_addr + ONE_ADDR;
        if (r_addr == LAST_ADDR) begin
          w_next_state = READY;
        end else begin
          w_next_state = CLEAR;
        end
      end
      READY: begin
        w_next_state = READY;
      end
      default: begin
        w_next_state = CLEAR;
        w_next_addr  = {ADDR_W{1'b0}};
      end
    endcase
  end

  // State, address counter and busy flag; reset restarts clearing at 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= CLEAR;
      r_addr  <= {ADDR_W{1'b0}};
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_addr  <= w_next_addr;
      r_busy  <= (w_next_state == CLEAR);
    end
  end

  assign o_init_busy = r_busy;
  assign o_clr_we    = (r_state == CLEAR);
  assign o_clr_addr  = r_addr;

endmodule

// File: rtl/param_dual_port_ram.sv
// Parametrised true dual-port synchronous RAM with per-port enables,
// read-valid strobes, post-reset clear and write-collision flag.
// Optional feature macro: DPRAM_PARITY_EN stores an even-parity bit per
// word and flags parity errors on read.
module param_dual_port_ram
  import dpram_pkg::*;
#(
  parameter int                ADDR_W    = 6,
  parameter int                DATA_W    = 8,
  parameter int                RD_MODE   = 0,
  parameter int                OUT_REG   = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              init_busy,
  output logic              collision,
  output logic              parity_err
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef DPRAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  logic [MEM_W-1:0]  r_mem [DEPTH];

  logic              w_init_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;

  logic [MEM_W-1:0]  w_a_word;
  logic [MEM_W-1:0]  w_b_word;
  logic [MEM_W-1:0]  w_clr_word;
  logic [MEM_W-1:0]  w_a_sel;
  logic [MEM_W-1:0]  w_b_sel;
  logic              w_a_perr;
  logic              w_b_perr;

  logic              w_ready;
  logic              w_a_acc;
  logic              w_b_acc;
  logic              w_a_wr;
  logic              w_b_wr;
  logic              w_collide;

  logic [DATA_W-1:0] r_a_d1;
  logic [DATA_W-1:0] r_b_d1;
  logic              r_a_v1;
  logic              r_b_v1;
  logic              r_a_e1;
  logic              r_b_e1;
  logic              r_collision;

  dpram_clear_seq #(
    .ADDR_W(ADDR_W)
  ) u_clear_seq (
    .i_clk      (clk),
    .i_rst      (rst),
    .o_init_busy(w_init_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  // Stored words carry an even-parity bit on top when the feature is built in.
`ifdef DPRAM_PARITY_EN
  assign w_a_word   = {even_parity(PAR_MAX_W'(a_wdata)), a_wdata};
  assign w_b_word   = {even_parity(PAR_MAX_W'(b_wdata)), b_wdata};
  assign w_clr_word = {even_parity(PAR_MAX_W'(CLEAR_VAL)), CLEAR_VAL};
`else
  assign w_a_word   = a_wdata;
  assign w_b_word   = b_wdata;
  assign w_clr_word = CLEAR_VAL;
`endif

  // Accesses are only honoured once the clear sequence has finished.
  assign w_ready   = ~w_init_busy;
  assign w_a_acc   = w_ready & a_en;
  assign w_b_acc   = w_ready & b_en;
  assign w_a_wr    = w_a_acc & a_we;
  assign w_b_wr    = w_b_acc & b_we;
  assign w_collide = w_a_wr & w_b_wr & (a_addr == b_addr);

  // Own-port write-first returns the incoming word; every other case reads
  // the array, which still holds the pre-write contents at this edge.
  assign w_a_sel = ((RD_MODE == WR_FIRST) && a_we) ? w_a_word : r_mem[a_addr];
  assign w_b_sel = ((RD_MODE == WR_FIRST) && b_we) ? w_b_word : r_mem[b_addr];

`ifdef DPRAM_PARITY_EN
  assign w_a_perr = even_parity(PAR_MAX_W'(w_a_sel[DATA_W-1:0])) ^ w_a_sel[DATA_W];
  assign w_b_perr = even_parity(PAR_MAX_W'(w_b_sel[DATA_W-1:0])) ^ w_b_sel[DATA_W];
`else
  assign w_a_perr = 1'b0;
  assign w_b_perr = 1'b0;
`endif

  // Array writes: clear has the port, otherwise A is applied last so it wins
  // a same-address collision with B.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= w_clr_word;
    end else begin
      if (w_b_wr) begin
        r_mem[b_addr] <= w_b_word;
      end
      if (w_a_wr) begin
        r_mem[a_addr] <= w_a_word;
      end
    end
  end

  // First read stage: data holds when idle, valid/error follow acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_d1      <= {DATA_W{1'b0}};
      r_b_d1      <= {DATA_W{1'b0}};
      r_a_v1      <= 1'b0;
      r_b_v1      <= 1'b0;
      r_a_e1      <= 1'b0;
      r_b_e1      <= 1'b0;
      r_collision <= 1'b0;
    end else begin
      r_a_v1      <= w_a_acc;
      r_b_v1      <= w_b_acc;
      r_a_e1      <= w_a_acc & w_a_perr;
      r_b_e1      <= w_b_acc & w_b_perr;
      r_collision <= w_collide;
      if (w_a_acc) begin
        r_a_d1 <= w_a_sel[DATA_W-1:0];
      end
      if (w_b_acc) begin
        r_b_d1 <= w_b_sel[DATA_W-1:0];
      end
    end
  end

  generate
    if (OUT_REG == 1) begin : g_out_reg
      logic [DATA_W-1:0] r_a_d2;
      logic [DATA_W-1:0] r_b_d2;
      logic              r_a_v2;
      logic              r_b_v2;
      logic              r_a_e2;
      logic              r_b_e2;

      // Second read stage: one extra cycle of latency, same hold behaviour.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a_d2 <= {DATA_W{1'b0}};
          r_b_d2 <= {DATA_W{1'b0}};
          r_a_v2 <= 1'b0;
          r_b_v2 <= 1'b0;
          r_a_e2 <= 1'b0;
          r_b_e2 <= 1'b0;
        end else begin
          r_a_v2 <= r_a_v1;
          r_b_v2 <= r_b_v1;
          r_a_e2 <= r_a_e1;
          r_b_e2 <= r_b_e1;
          if (r_a_v1) begin
            r_a_d2 <= r_a_d1;
          end
          if (r_b_v1) begin
            r_b_d2 <= r_b_d1;
          end
        end
      end

      assign a_rdata    = r_a_d2;
      assign b_rdata    = r_b_d2;
      assign a_rvalid   = r_a_v2;
      assign b_rvalid   = r_b_v2;
      assign parity_err = r_a_e2 | r_b_e2;
    end else begin : g_no_out_reg
      assign a_rdata    = r_a_d1;
      assign b_rdata    = r_b_d1;
      assign a_rvalid   = r_a_v1;
      assign b_rvalid   = r_b_v1;
      assign parity_err = r_a_e1 | r_b_e1;
    end
  endgenerate

  assign init_busy = w_init_busy;
  assign collision = r_collision;

endmodule
